// File: rtl/spi_avalon_pkg.sv
// rtl/spi_avalon_pkg.sv - shared types and constants for the SPI Avalon command master
package spi_avalon_pkg;

    localparam int         DATA_W      = 32;
    localparam logic [7:0] TX_ADDR_DEF = 8'h00;
    localparam logic [7:0] RX_ADDR_DEF = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WAIT_IRQ,
        ST_RD,
        ST_RESP
    } state_t;

endpackage

// File: rtl/avalon_mm_access.sv
// rtl/avalon_mm_access.sv - single Avalon-MM access engine, strobes held until wait_request drops
module avalon_mm_access
    import spi_avalon_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              start_read,
    input  logic [7:0]        start_address,
    input  logic [DATA_W-1:0] start_write_data,
    input  logic              wait_request,
    output logic              done,
    output logic [7:0]        av_address,
    output logic              av_chip_select,
    output logic              av_write,
    output logic [DATA_W-1:0] av_write_data,
    output logic              av_read
);

    // done marks the cycle the slave accepts the access; strobes drop on the following edge
    assign done = av_chip_select & ~wait_request;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            av_address     <= '0;
            av_chip_select <= 1'b0;
            av_write       <= 1'b0;
            av_write_data  <= '0;
            av_read        <= 1'b0;
        end else if (start) begin
            av_chip_select <= 1'b1;
            av_write       <= ~start_read;
            av_read        <= start_read;
            av_address     <= start_address;
            if (!start_read) begin
                av_write_data <= start_write_data;
            end
        end else if (done) begin
            av_chip_select <= 1'b0;
            av_write       <= 1'b0;
            av_read        <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_avalon_cmd_master.sv
// rtl/spi_avalon_cmd_master.sv - command/response stream to SPI Avalon bridge master
module spi_avalon_cmd_master
    import spi_avalon_pkg::*;
#(
    parameter logic [7:0] TX_ADDR     = TX_ADDR_DEF,
    parameter logic [7:0] RX_ADDR     = RX_ADDR_DEF,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         TO_W        = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_no_rsp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [7:0]        av_address,
    output logic              av_chip_select,
    output logic              av_write,
    output logic [DATA_W-1:0] av_write_data,
    output logic              av_read,
    input  logic [DATA_W-1:0] av_read_data,
    input  logic              av_wait_request,
    input  logic              irq,
    output logic              busy,
    output logic [7:0]        err_count
);

    state_t            state, state_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              no_rsp_q, no_rsp_d;
    logic [DATA_W-1:0] rsp_data_d;
    logic              rsp_err_d;
    logic [7:0]        err_count_d;
    logic              acc_start, acc_read, acc_done, timeout;

    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    avalon_mm_access u_access (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (acc_start),
        .start_read       (acc_read),
        .start_address    (acc_read ? RX_ADDR : TX_ADDR),
        .start_write_data (cmd_data),
        .wait_request     (av_wait_request),
        .done             (acc_done),
        .av_address       (av_address),
        .av_chip_select   (av_chip_select),
        .av_write         (av_write),
        .av_write_data    (av_write_data),
        .av_read          (av_read)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            no_rsp_q  <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_d;
            no_rsp_q  <= no_rsp_d;
            cmd_ready <= (state_nxt == ST_IDLE);
            rsp_valid <= (state_nxt == ST_RESP);
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= (state_nxt != ST_IDLE);
            err_count <= err_count_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (cmd_valid && cmd_ready) state_nxt = ST_WR;
            ST_WR:       if (acc_done) state_nxt = no_rsp_q ? ST_IDLE : ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                // irq takes priority over a timeout landing in the same cycle
                if (irq)          state_nxt = ST_RD;
                else if (timeout) state_nxt = ST_RESP;
            end
            ST_RD:       if (acc_done) state_nxt = ST_RESP;
            ST_RESP:     if (rsp_valid && rsp_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_start   = 1'b0;
        acc_read    = (state == ST_WAIT_IRQ);
        to_cnt_d    = to_cnt;
        no_rsp_d    = no_rsp_q;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        err_count_d = err_count;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    acc_start = 1'b1;
                    no_rsp_d  = cmd_no_rsp;
                end
            end
            ST_WR: to_cnt_d = '0;
            ST_WAIT_IRQ: begin
                if (irq) begin
                    acc_start = 1'b1;
                end else if (timeout) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            ST_RD: begin
                if (acc_done) begin
                    rsp_data_d = av_read_data;
                    rsp_err_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_avalon_cmd_master.sv
// tb/tb_spi_avalon_cmd_master.sv - randomized transaction-level bench for spi_avalon_cmd_master
module tb_spi_avalon_cmd_master;

    localparam int         TO  = 16;
    localparam logic [7:0] TXA = 8'h00;
    localparam logic [7:0] RXA = 8'h04;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_no_rsp;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [7:0]  av_address;
    logic        av_chip_select, av_write, av_read, av_wait_request;
    logic [31:0] av_write_data, av_read_data;
    logic        irq, busy;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_errs = 0;
    int lim;

    always #5 clk = ~clk;

    spi_avalon_cmd_master #(
        .TX_ADDR     (TXA),
        .RX_ADDR     (RXA),
        .TIMEOUT_CYC (TO),
        .TO_W        (5)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .cmd_no_rsp      (cmd_no_rsp),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .av_address      (av_address),
        .av_chip_select  (av_chip_select),
        .av_write        (av_write),
        .av_write_data   (av_write_data),
        .av_read         (av_read),
        .av_read_data    (av_read_data),
        .av_wait_request (av_wait_request),
        .irq             (irq),
        .busy            (busy),
        .err_count       (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One command end to end. ww/rw: wait states on write/read; d: cycles after write
    // completion before irq rises (d >= TO means timeout); bp: rsp_ready stall cycles.
    task automatic run_cmd(input logic [31:0] data, input bit nr, input int ww, input int rw,
                           input int d, input int bp, input logic [31:0] rdata);
        int          e0, ew, wsl, bpl, nwr, nrd, exp_lat;
        bit          in_acc, got_rsp, hs, fin, to_exp, isw0;
        logic [7:0]  a0;
        logic [31:0] wd0, rd_hold;
        to_exp  = !nr && (d >= TO);
        exp_lat = to_exp ? (ww + 1 + TO) : (ww + 1 + d + 1 + rw + 1);
        ew = -1; wsl = 0; bpl = 0; nwr = 0; nrd = 0;
        in_acc = 0; got_rsp = 0; hs = 0; fin = 0; isw0 = 0;
        a0 = '0; wd0 = '0; rd_hold = '0;
        rsp_ready = 0; av_wait_request = 0;
        cmd_valid = 1; cmd_data = data; cmd_no_rsp = nr; irq = 1'($urandom);
        lim = 0;
        while (!cmd_ready && lim < 50) begin
            tick();
            irq = 1'($urandom);
            lim++;
        end
        chk("accept_ready", 32'(cmd_ready), 1);
        tick();
        e0 = cyc;
        cmd_valid = 0; cmd_data = $urandom; cmd_no_rsp = 1'($urandom);
        chk("ready_drop", 32'(cmd_ready), 0);
        for (int c = 0; c < 400 && !fin; c++) begin
            if (c > 0) tick();
            if (hs) begin
                chk("rsp_drop", 32'(rsp_valid), 0);
                chk("ready_back", 32'(cmd_ready), 1);
                chk("idle_busy", 32'(busy), 0);
                rsp_ready = 0;
                fin = 1;
            end else if (nr && ew >= 0 && cyc >= ew) begin
                chk("nr_ready", 32'(cmd_ready), 1);
                chk("nr_busy", 32'(busy), 0);
                chk("nr_no_rsp", 32'(rsp_valid), 0);
                chk("nr_no_read", 32'(av_read), 0);
                irq = 1;
                if (cyc >= ew + 3) fin = 1;
            end else begin
                chk("busy", 32'(busy), 1);
                if (ew < 0 || nr) irq = 1'($urandom);
                else              irq = (nrd == 0) && (cyc - ew >= d);
                chk("no_both", 32'(av_write & av_read), 0);
                chk("cs_strobe", 32'(av_chip_select), 32'(av_write | av_read));
                av_read_data = $urandom;
                if (av_write || av_read) begin
                    if (!in_acc) begin
                        in_acc = 1; a0 = av_address; wd0 = av_write_data; isw0 = av_write;
                        wsl = av_write ? ww : rw;
                    end else begin
                        chk("hold_addr", 32'(av_address), 32'(a0));
                        chk("hold_kind", 32'(av_write), 32'(isw0));
                        if (isw0) chk("hold_wdata", av_write_data, wd0);
                    end
                    av_wait_request = (wsl > 0);
                    if (wsl > 0) wsl--;
                    else begin
                        in_acc = 0;
                        if (isw0) begin
                            nwr++;
                            ew = cyc + 1;
                            chk("wr_addr", 32'(a0), 32'(TXA));
                            chk("wr_data", wd0, data);
                        end else begin
                            nrd++;
                            av_read_data = rdata;
                            chk("rd_addr", 32'(a0), 32'(RXA));
                        end
                    end
                end else begin
                    av_wait_request = 1'($urandom);
                end
                if (got_rsp) begin
                    chk("rsp_hold_valid", 32'(rsp_valid), 1);
                    chk("rsp_hold_data", rsp_data, rd_hold);
                    chk("rsp_cmd_ready", 32'(cmd_ready), 0);
                end else if (rsp_valid) begin
                    got_rsp = 1;
                    bpl = bp;
                    rd_hold = rsp_data;
                    chk("rsp_latency", cyc - e0, exp_lat);
                    chk("rsp_err", 32'(rsp_err), 32'(to_exp));
                    chk("rsp_data", rsp_data, to_exp ? 32'd0 : rdata);
                    chk("rsp_cmd_ready", 32'(cmd_ready), 0);
                    if (to_exp && exp_errs < 255) exp_errs++;
                    chk("err_count", 32'(err_count), exp_errs);
                end
                if (got_rsp) begin
                    if (bpl == 0) begin
                        rsp_ready = 1;
                        hs = 1;
                    end else begin
                        bpl--;
                    end
                end
            end
        end
        chk("bounded", 32'(fin), 1);
        chk("n_wr", nwr, 1);
        chk("n_rd", nrd, (nr || to_exp) ? 0 : 1);
        irq = 0; av_wait_request = 0; rsp_ready = 0;
    endtask

    initial begin
        reset_n = 0; cmd_valid = 0; cmd_data = '0; cmd_no_rsp = 0; rsp_ready = 0;
        av_read_data = '0; av_wait_request = 0; irq = 0;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({av_chip_select, av_write, av_read}), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_rsp", 32'({rsp_err, rsp_data}), 0);
        reset_n = 1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);

        run_cmd(32'hA5A5_0001, 0, 0, 0, 0, 0, 32'h1234_5678);
        run_cmd(32'hC0DE_0002, 0, 3, 2, 0, 0, 32'h0BAD_F00D);
        run_cmd(32'h0000_00FF, 1, 0, 0, 0, 0, 32'h0);
        run_cmd(32'h1111_2222, 0, 0, 0, 1000, 0, 32'hDEAD_BEEF);
        chk("err_one", 32'(err_count), 1);
        run_cmd(32'h3333_4444, 0, 1, 1, TO - 1, 0, 32'h5A5A_5A5A);
        run_cmd(32'h5555_6666, 0, 0, 0, TO, 0, 32'h7777_8888);
        run_cmd(32'h9999_AAAA, 0, 0, 0, 2, 10, 32'hBBBB_CCCC);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            run_cmd($urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, 4),
                    $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 2, TO + 4) : $urandom_range(0, 5),
                    $urandom_range(0, 4), $urandom);
        end

        for (int i = 0; i < 300; i++) begin
            run_cmd($urandom, 0, 0, 0, 1000, 0, $urandom);
        end
        chk("err_saturated", 32'(err_count), 255);

        // reset while a read is stalled by the slave
        cmd_valid = 1; cmd_data = 32'h5555_AAAA; cmd_no_rsp = 0; irq = 1; av_wait_request = 0;
        lim = 0;
        while (!cmd_ready && lim < 20) begin tick(); lim++; end
        tick();
        cmd_valid = 0;
        lim = 0;
        while (!av_read && lim < 20) begin tick(); lim++; end
        chk("rd_reached", 32'(av_read), 1);
        av_wait_request = 1;
        tick(); tick();
        chk("rd_stalled", 32'(av_read), 1);
        #2 reset_n = 0;
        #1;
        chk("async_rst_strobes", 32'({av_chip_select, av_write, av_read}), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        tick();
        reset_n = 1; av_wait_request = 0; irq = 0;
        tick();
        exp_errs = 0;
        chk("rerst_ready", 32'(cmd_ready), 1);
        chk("rerst_busy", 32'(busy), 0);
        chk("rerst_err_count", 32'(err_count), 0);
        run_cmd(32'hFEED_0001, 0, 0, 0, 0, 0, 32'hCAFE_0002);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
